ram_clear_seq: RTL

- Power-on and on-demand data-RAM clear sequencer; sits upstream of the CPU and the data RAM in the top level.
- Drives the RAM's second write port (address_b/data_b/wren_b) to sweep every word to CLEAR_VALUE.
- Holds the CPU in reset (drives its resetN) until the sweep completes, so the CPU never sees stale RAM contents.

---
 rtl/ram_clear_seq_if.sv | 23 ++
 rtl/ram_clear_seq.sv | 85 ++++++++
 2 files changed

// File: rtl/ram_clear_seq_if.sv
// Port-b write bus and CPU-control handshake between the RAM clear sequencer and the top level.
interface ram_clear_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  start_clear;
    logic [ADDR_WIDTH-1:0] clr_address;
    logic [DATA_WIDTH-1:0] clr_data;
    logic                  clr_wren;
    logic                  cpu_resetN;
    logic                  busy;
    logic                  done;

    modport master (
        input  start_clear,
        output clr_address, clr_data, clr_wren, cpu_resetN, busy, done
    );

    modport slave (
        output start_clear,
        input  clr_address, clr_data, clr_wren, cpu_resetN, busy, done
    );
endinterface

// File: rtl/ram_clear_seq.sv
// Sweeps every data-RAM word to CLEAR_VALUE through port b while holding the CPU in reset,
// on power-up and again whenever start_clear arrives while the CPU is running.
module ram_clear_seq #(
    parameter int                    DATA_WIDTH         = 16,
    parameter int                    RAM_REGISTER_COUNT = 1024,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE        = '0
) (
    input logic               Clk,
    input logic               Reset,
    ram_clear_seq_if.master   bus
);
    localparam int ADDR_WIDTH = $clog2(RAM_REGISTER_COUNT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_REGISTER_COUNT - 1);

    localparam logic [1:0] HOLD   = 2'd0;
    localparam logic [1:0] CLEAR  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] RUN    = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] counter;
    logic                  wren_q;
    logic                  resetn_q;
    logic                  busy_q;
    logic                  done_q;

    // Outputs are loaded together with the next state, so each one reflects the state it belongs to.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= HOLD;
            counter  <= '0;
            wren_q   <= 1'b0;
            resetn_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                HOLD: begin
                    state   <= CLEAR;
                    counter <= '0;
                    wren_q  <= 1'b1;
                    busy_q  <= 1'b1;
                end
                CLEAR: begin
                    // Power-of-two depth lets the counter wrap back to 0 on the last write.
                    counter <= counter + ADDR_WIDTH'(1);
                    if (counter == LAST_ADDR) begin
                        state  <= SETTLE;
                        wren_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    state    <= RUN;
                    resetn_q <= 1'b1;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                RUN: begin
                    if (bus.start_clear) begin
                        state    <= CLEAR;
                        counter  <= '0;
                        wren_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        resetn_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= HOLD;
                    counter  <= '0;
                    wren_q   <= 1'b0;
                    resetn_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clr_address = counter;
    assign bus.clr_data    = CLEAR_VALUE;
    assign bus.clr_wren    = wren_q;
    assign bus.cpu_resetN  = resetn_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule
